// File: rtl/key_debounce_if.sv
// Key debounce bus: raw pushbutton pins in, conditioned level and strobes out.
interface key_debounce_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] repeat_pulse;

    // Board / consumer side: drives the pins, observes the conditioned outputs.
    modport master (
        output key_raw,
        input  key_level, press_pulse, release_pulse, repeat_pulse
    );

    // Debouncer side.
    modport slave (
        input  key_raw,
        output key_level, press_pulse, release_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Pushbutton debouncer: per-key 2-flop synchronizer, debounce FSM and
// hold/auto-repeat timer. key_level feeds the keys PIO in_port; the strobes
// serve hardware consumers that bypass the PIO.

// One key: synchronizer, debounce counter, FSM and hold/repeat timer.
module key_debounce_lane #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    localparam logic             RAW_IDLE  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, P_WAIT, PRESSED, R_WAIT} state_t;

    logic             r_sync1, r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_rep_phase;
    logic             r_level, r_press, r_release, r_repeat;
    logic             w_s;
    logic             w_hold_hit;

    // Normalized sample: 1 means pressed regardless of pin polarity.
    assign w_s        = r_sync2 ^ RAW_IDLE;
    // First strobe after the long hold, then the shorter repeat period.
    assign w_hold_hit = r_rep_phase ? (r_hcnt == REP_LAST) : (r_hcnt == HOLD_LAST);

    // Two-flop synchronizer; resets to the released pin level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= RAW_IDLE;
            r_sync2 <= RAW_IDLE;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM with hold/repeat timer; all outputs registered, strobes one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            r_rep_phase <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= P_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                P_WAIT: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (r_dcnt == DB_LAST) begin
                        r_state     <= PRESSED;
                        r_level     <= 1'b1;
                        r_press     <= 1'b1;
                        r_hcnt      <= '0;
                        r_rep_phase <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        // hcnt is left frozen so a rejected release glitch resumes the hold.
                        r_state <= R_WAIT;
                        r_dcnt  <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (w_hold_hit) begin
                            r_repeat    <= 1'b1;
                            r_hcnt      <= '0;
                            r_rep_phase <= 1'b1;
                        end else begin
                            r_hcnt <= r_hcnt + CNT_ONE;
                        end
                    end
                end
                R_WAIT: begin
                    if (w_s) begin
                        r_state <= PRESSED;
                    end else if (r_dcnt == DB_LAST) begin
                        r_state     <= IDLE;
                        r_level     <= 1'b0;
                        r_release   <= 1'b1;
                        r_hcnt      <= '0;
                        r_rep_phase <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = (REPEAT_EN != 0) ? r_repeat : 1'b0;
endmodule

// Top: one independent lane per key.
module key_debounce #(
    parameter int NUM_KEYS        = 3,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic          clk,
    input  logic          reset,
    key_debounce_if.slave bus
);
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] w_repeat;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_raw     (bus.key_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g])
        );
    end

    assign bus.key_level     = w_level;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.repeat_pulse  = w_repeat;
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random pin activity, all
// checked against a run-length / held-time reference model.
module tb_key_debounce;
    localparam int NK   = 3;
    localparam int AL   = 1;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    key_debounce_if #(.NUM_KEYS(NK)) bus();

    key_debounce #(
        .NUM_KEYS(NK), .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: pressed-sense samples delayed two edges; a change is
    // accepted once the sample has disagreed with the level for DB+1 edges;
    // held counts edges spent pressed with no release pending.
    logic [NK-1:0] m_d1, m_d2, m_level, m_press, m_rel, m_rep;
    int m_run [NK];
    int m_held[NK];

    function automatic void model_reset();
        m_d1 = '0; m_d2 = '0; m_level = '0;
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int k = 0; k < NK; k++) begin
            m_run[k] = 0; m_held[k] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [NK-1:0] raw);
        logic [NK-1:0] s;
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = (AL != 0) ? ~raw : raw;
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int k = 0; k < NK; k++) begin
            if (s[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DB + 1) begin
                    m_level[k] = s[k];
                    if (s[k]) m_press[k] = 1'b1;
                    else      m_rel[k]   = 1'b1;
                    m_run[k]  = 0;
                    m_held[k] = 0;
                end
            end else begin
                if (m_level[k] && m_run[k] == 0) begin
                    m_held[k]++;
                    if (m_held[k] >= HOLD && (m_held[k] - HOLD) % REP == 0) m_rep[k] = 1'b1;
                end
                m_run[k] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bus.key_raw);
        #1;
        chk("level",   32'(bus.key_level),     32'(m_level));
        chk("press",   32'(bus.press_pulse),   32'(m_press));
        chk("release", 32'(bus.release_pulse), 32'(m_rel));
        chk("repeat",  32'(bus.repeat_pulse),  32'(m_rep));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({bus.key_level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse}), 32'h0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt, nrel, rel_edge, press_edge;
        int reps[$];
        int hold[NK];

        bus.key_raw = '1;
        model_reset();
        #12;
        chk_all_zero("reset_state");
        reset = 1'b0;

        // 1: clean press on key 0, accepted at edge 7 only
        bus.key_raw[0] = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            if (t == 6) chk("s1_level_e6", 32'(bus.key_level), 32'h0);
            if (t == 7) begin
                chk("s1_press_e7", 32'(bus.press_pulse), 32'h1);
                chk("s1_level_e7", 32'(bus.key_level),   32'h1);
            end
            if (t == 8) chk("s1_press_e8", 32'(bus.press_pulse), 32'h0);
        end

        // 2: key 1 bounces every 2 cycles, then released: nothing accepted
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            bus.key_raw[1] = ((t / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            if (bus.key_level[1] | bus.press_pulse[1] | bus.release_pulse[1]) cnt++;
        end
        bus.key_raw[1] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            if (bus.key_level[1] | bus.press_pulse[1] | bus.release_pulse[1]) cnt++;
        end
        chk("s2_key1_activity", 32'(cnt), 32'h0);

        // 3: release of key 0 with a glitch back low
        bus.key_raw[0] = 1'b1; step(); step();
        bus.key_raw[0] = 1'b0; step();
        bus.key_raw[0] = 1'b1;
        nrel = 0; rel_edge = -1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 6) chk("s3_level_held", 32'(bus.key_level[0]), 32'h1);
            if (bus.release_pulse[0]) begin nrel++; rel_edge = t; end
        end
        chk("s3_release_count", 32'(nrel), 32'h1);
        chk("s3_release_edge",  32'(rel_edge), 32'h7);
        settle(4);

        // 4: auto-repeat on key 2
        bus.key_raw[2] = 1'b0;
        reps = {};
        for (int t = 1; t <= 45; t++) begin
            step();
            if (bus.repeat_pulse[2]) reps.push_back(t);
        end
        chk("s4_rep_count", 32'(reps.size()), 32'h3);
        chk("s4_rep0", 32'((reps.size() > 0) ? reps[0] : -1), 32'd27);
        chk("s4_rep1", 32'((reps.size() > 1) ? reps[1] : -1), 32'd35);
        chk("s4_rep2", 32'((reps.size() > 2) ? reps[2] : -1), 32'd43);
        bus.key_raw[2] = 1'b1;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (bus.repeat_pulse[2]) cnt++;
        end
        chk("s4_no_rep_after_release", 32'(cnt), 32'h0);
        bus.key_raw[2] = 1'b0;
        reps = {}; press_edge = -1;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (bus.press_pulse[2]) press_edge = t;
            if (bus.repeat_pulse[2]) reps.push_back(t);
        end
        chk("s4_repress_edge", 32'(press_edge), 32'd7);
        chk("s4_repress_rep0", 32'((reps.size() > 0) ? reps[0] : -1), 32'd27);
        bus.key_raw[2] = 1'b1;
        settle(12);

        // 5: keys 0 and 2 pressed together
        bus.key_raw = 3'b010;
        cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            step();
            if (t == 7) chk("s5_press_e7", 32'(bus.press_pulse), 32'h5);
            if (bus.press_pulse != '0) cnt++;
        end
        chk("s5_press_cycles", 32'(cnt), 32'h1);
        bus.key_raw = '1;
        settle(12);

        // 6a: reset during P_WAIT
        bus.key_raw[0] = 1'b0;
        settle(4);
        #3; reset = 1'b1; model_reset();
        #1; chk_all_zero("s6_reset_pwait");
        bus.key_raw = '1;
        #2; reset = 1'b0;
        settle(8);

        // 6b: reset during PRESSED
        bus.key_raw[2] = 1'b0;
        settle(9);
        chk("s6_pressed_before", 32'(bus.key_level), 32'h4);
        #3; reset = 1'b1; model_reset();
        #1; chk_all_zero("s6_reset_pressed");
        bus.key_raw = '1;
        #2; reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            step();
            chk_all_zero("s6_after_reset");
        end

        // random pin activity: short bounces and long holds
        for (int k = 0; k < NK; k++) hold[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    bus.key_raw[k] = ~bus.key_raw[k];
                    hold[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 8));
                end
                hold[k]--;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces and conditions the raw DE2 pushbutton inputs before they enter the keys PIO.
- Its `key_level` output drives the PIO `in_port` directly. The PIO's edge capture therefore sees one clean rising edge per physical press.
- Also provides single-cycle press, release and auto-repeat strobes for hardware consumers that bypass the PIO.
- Each key is handled by its own independent synchronizer, counter and FSM.

Parameters:
- NUM_KEYS, 3, number of keys handled.
- ACTIVE_LOW, 1, when 1 the raw inputs are low when pressed; when 0 they are high when pressed.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required to accept a change (10 ms at 50 MHz); must be >= 2.
- REPEAT_EN, 1, enables auto-repeat strobes when 1.
- HOLD_CYCLES, 25000000, press duration before the first repeat strobe (0.5 s); must be >= 2.
- REPEAT_CYCLES, 5000000, period between subsequent repeat strobes (0.1 s); must be >= 2.
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- key_raw  input  NUM_KEYS  raw, unsynchronized pushbutton pins.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed; feeds the PIO `in_port`.
- press_pulse  output  NUM_KEYS  1-cycle strobe on an accepted press.
- release_pulse  output  NUM_KEYS  1-cycle strobe on an accepted release.
- repeat_pulse  output  NUM_KEYS  1-cycle auto-repeat strobe.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high. Clock port is `clk`, reset port is `reset`.
- Reset, asserted at any time including mid-debounce:
  - Both synchronizer flops go to the inactive raw level (1 if ACTIVE_LOW, else 0).
  - Every FSM goes to IDLE and all counters clear.
  - All outputs are 0.
- Synchronizer: two flops per key. Normalized sample s = sync2 XOR ACTIVE_LOW, so s = 1 means pressed.
- All outputs are registered. Pulses last exactly one cycle.
- Per-key FSM, with debounce counter dcnt:
  - IDLE (level 0): if s = 1, go to P_WAIT with dcnt = 0.
  - P_WAIT (level 0):
    - If s = 0, return to IDLE; the bounce is rejected and no pulse is issued.
    - Else if dcnt = DEBOUNCE_CYCLES-1, go to PRESSED. Set level to 1, assert press_pulse, clear hcnt and the repeat phase.
    - Otherwise increment dcnt.
  - PRESSED (level 1):
    - If s = 0, go to R_WAIT with dcnt = 0. hcnt is frozen.
    - Otherwise run the hold/repeat logic below.
  - R_WAIT (level 1):
    - If s = 1, return to PRESSED with no pulse; hcnt resumes from its frozen value.
    - Else if dcnt = DEBOUNCE_CYCLES-1, go to IDLE. Set level to 0, assert release_pulse, clear hcnt.
    - Otherwise increment dcnt.
- Press latency:
  - Edge 1 is the first edge that samples a new stable raw value.
  - sync2 updates at edge 2; P_WAIT is entered at edge 3.
  - key_level rises and press_pulse asserts at edge DEBOUNCE_CYCLES+3. Release latency is identical.
- Hold/repeat (only when REPEAT_EN = 1; otherwise repeat_pulse is tied to 0):
  - hcnt increments every cycle spent in PRESSED.
  - First phase: when hcnt = HOLD_CYCLES-1, assert repeat_pulse, clear hcnt, and enter the repeat phase.
  - Repeat phase: when hcnt = REPEAT_CYCLES-1, assert repeat_pulse and clear hcnt.
  - If PRESSED is entered at edge E, strobes occur at edge E+HOLD_CYCLES, then every REPEAT_CYCLES cycles.
  - No repeat_pulse is ever issued in the same cycle as press_pulse.
- Keys are fully independent. Simultaneous presses produce simultaneous pulses on their respective bits.
- Counters never wrap: each one is cleared on its transition, before reaching its limit.
- No combinational path from key_raw to any output.

Test Plan:
Bench parameters: NUM_KEYS = 3, ACTIVE_LOW = 1, DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 20, REPEAT_CYCLES = 8, REPEAT_EN = 1.
1. Clean press: drive key_raw[0] to 0, first sampled at edge 1 -> key_level[0] = 1 and press_pulse[0] = 1 at edge 7 only; other bits stay 0.
2. Press bounce: key_raw[1] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> key_level[1] stays 0; no pulses.
3. Release with bounce: key 0 held, then raw returns high for 2 cycles, low for 1 cycle, then high -> level stays 1 through the glitch; release_pulse[0] fires once, 7 edges after the final stable high is first sampled.
4. Auto-repeat: hold key 2 low, PRESSED at edge 7 -> repeat_pulse[2] at edges 27, 35, 43; release -> repeat pulses stop and hcnt clears; a new press has its first repeat 20 cycles after PRESSED.
5. Simultaneous: keys 0 and 2 pressed in the same cycle -> press_pulse = 3'b101 in a single cycle.
6. Reset mid-operation: assert reset asynchronously during P_WAIT and during PRESSED -> all outputs are 0 immediately; after deassertion with raw = 3'b111, outputs stay 0.
